// File: rtl/lsu_types.sv
// Shared LSU types: arbiter FSM state encoding and data-cache port widths.
package lsu_types;

  localparam int XLEN      = 32;
  localparam int DC_MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LD,
    WAIT_ST
  } lsq_arb_state_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] addr
  );
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsq_dmem_arbiter.sv
// Store/load queue arbiter onto a single-outstanding data-cache port.
// Define LSQ_ARB_FAIRNESS_EN to bound store bursts while a load waits.
module lsq_dmem_arbiter
  import lsu_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 backend_flush,
  input  logic                 stq_valid,
  output logic                 stq_ready,
  input  logic [XLEN-1:0]      stq_addr,
  input  logic [DC_MASK_W-1:0] stq_wmask,
  input  logic [XLEN-1:0]      stq_wdata,
  input  logic                 ldq_valid,
  output logic                 ldq_ready,
  input  logic [XLEN-1:0]      ldq_addr,
  input  logic [DC_MASK_W-1:0] ldq_rmask,
  output logic                 ldq_resp_valid,
  output logic [XLEN-1:0]      ldq_resp_rdata,
  output logic                 dc_valid,
  input  logic                 dc_ready,
  output logic [XLEN-1:0]      dc_addr,
  output logic [DC_MASK_W-1:0] dc_rmask,
  output logic [DC_MASK_W-1:0] dc_wmask,
  output logic [XLEN-1:0]      dc_wdata,
  input  logic                 dc_resp_valid,
  input  logic [XLEN-1:0]      dc_resp_rdata
);

  lsq_arb_state_t state, state_nxt;
  logic squash, squash_nxt;
  logic idle;
  logic starved;
  logic grant_st, grant_ld;
  logic xfer_st, xfer_ld;

  // Async reset forces IDLE, but inputs may still be valid, so gate on rst too.
  assign idle = (state == IDLE) && !rst;

`ifdef LSQ_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt, starve_nxt;

  assign starved = ldq_valid && (starve_cnt == LIMIT);

  always_comb begin
    starve_nxt = starve_cnt;
    if (!ldq_valid || xfer_ld)
      starve_nxt = '0;
    else if (xfer_st && (starve_cnt != LIMIT))
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_nxt;
  end
`else
  logic [31:0] unused_limit;

  assign unused_limit = 32'(STARVE_LIMIT);
  assign starved      = 1'b0;
`endif

  assign grant_st = stq_valid && !starved;
  assign grant_ld = !grant_st && ldq_valid && !backend_flush;

  always_comb begin
    dc_valid  = 1'b0;
    dc_addr   = '0;
    dc_rmask  = '0;
    dc_wmask  = '0;
    dc_wdata  = '0;
    stq_ready = 1'b0;
    ldq_ready = 1'b0;
    if (idle && grant_st) begin
      dc_valid  = 1'b1;
      dc_addr   = word_align(stq_addr);
      dc_wmask  = stq_wmask;
      dc_wdata  = stq_wdata;
      stq_ready = dc_ready;
    end else if (idle && grant_ld) begin
      dc_valid  = 1'b1;
      dc_addr   = word_align(ldq_addr);
      dc_rmask  = ldq_rmask;
      ldq_ready = dc_ready;
    end
  end

  // A requester handshake only happens together with the cache handshake.
  assign xfer_st = stq_ready;
  assign xfer_ld = ldq_ready;

  always_comb begin
    state_nxt      = state;
    squash_nxt     = squash;
    ldq_resp_valid = 1'b0;
    ldq_resp_rdata = '0;
    unique case (state)
      IDLE: begin
        if (xfer_st) begin
          state_nxt = WAIT_ST;
        end else if (xfer_ld) begin
          state_nxt  = WAIT_LD;
          squash_nxt = backend_flush;
        end
      end
      WAIT_LD: begin
        if (dc_resp_valid) begin
          state_nxt  = IDLE;
          squash_nxt = 1'b0;
          if (!squash && !backend_flush) begin
            ldq_resp_valid = 1'b1;
            ldq_resp_rdata = dc_resp_rdata;
          end
        end else if (backend_flush) begin
          squash_nxt = 1'b1;
        end
      end
      WAIT_ST: begin
        if (dc_resp_valid)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        squash_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      squash <= 1'b0;
    end else begin
      state  <= state_nxt;
      squash <= squash_nxt;
    end
  end

endmodule

// File: doc/lsq_dmem_arbiter.md
LSQ_DMEM_ARBITER -- requirements
Module: lsq_dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive store grants while a load is waiting.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: backend_flush  in  1  pipeline squash.
REQ-005 SHALL have ports: stq_valid in 1; stq_ready out 1; stq_addr in 32; stq_wmask in 4; stq_wdata in 32, forming the store-queue head write request.
REQ-006 SHALL have ports: ldq_valid in 1; ldq_ready out 1; ldq_addr in 32; ldq_rmask in 4, forming the load-queue read request.
REQ-007 SHALL have ports: ldq_resp_valid out 1; ldq_resp_rdata out 32, forming the load response.
REQ-008 SHALL have ports: dc_valid out 1; dc_ready in 1; dc_addr out 32; dc_rmask out 4; dc_wmask out 4; dc_wdata out 32; dc_resp_valid in 1; dc_resp_rdata in 32, forming the data-cache port.

Function
REQ-009 SHALL use an FSM with states IDLE, WAIT_LD and WAIT_ST, and SHALL allow at most one outstanding cache request.
REQ-010 SHALL drive dc_valid only in IDLE, and only when the granted requester is valid.
REQ-011 SHALL grant the store when stq_valid is high and the load is not starved; otherwise it SHALL grant the load when ldq_valid is high and backend_flush is low.
REQ-012 SHALL raise the load-starved condition when starve_cnt equals STARVE_LIMIT and ldq_valid is high.
REQ-013 SHALL assert stq_ready/ldq_ready combinationally only when that requester is granted, the FSM is in IDLE, and dc_ready is high, so that a requester transfer coincides with the cache transfer.
REQ-014 SHALL, for a store grant, drive dc_addr = {stq_addr[31:2],2'b00}, dc_wmask = stq_wmask, dc_rmask = 0 and dc_wdata = stq_wdata.
REQ-015 SHALL, for a load grant, drive dc_addr = {ldq_addr[31:2],2'b00}, dc_rmask = ldq_rmask and dc_wmask = 0.
REQ-016 SHALL, on a transfer (dc_valid & dc_ready), move from IDLE to WAIT_ST for a store or to WAIT_LD for a load; a non-transfer SHALL leave the FSM in IDLE.
REQ-017 SHALL leave WAIT_ST/WAIT_LD for IDLE on dc_resp_valid, with the next request issuable in the cycle after the response (minimum two cycles per access).
REQ-018 SHALL, in WAIT_LD on dc_resp_valid, assert ldq_resp_valid for exactly that cycle with ldq_resp_rdata = dc_resp_rdata, unless the access is squashed.
REQ-019 SHALL set a squash flag when backend_flush is high in WAIT_LD, or in the same cycle as a load transfer; a squashed response SHALL still return the FSM to IDLE, SHALL suppress ldq_resp_valid, and SHALL clear the flag.
REQ-020 SHALL NOT squash an in-flight store on backend_flush, since the store is committed, and SHALL still grant stores during a flush cycle.
REQ-021 SHALL ignore dc_resp_valid in IDLE.
REQ-022 SHALL keep starve_cnt 0 to STARVE_LIMIT, saturating: increment on a store transfer while ldq_valid is high, clear on a load transfer or while ldq_valid is low.
REQ-023 SHALL hold ldq_resp_rdata at 0 whenever ldq_resp_valid is low.

Reset
REQ-024 SHALL, on rst, asynchronously set state to IDLE, starve_cnt to 0 and squash to 0.
REQ-025 SHALL drive all outputs to 0 during reset; a response arriving after a mid-access reset SHALL be ignored (IDLE).
REQ-026 SHALL NOT reset the datapath outputs separately, as they derive combinationally from inputs gated by state.

Configuration
REQ-027 SHALL, when LSQ_ARB_FAIRNESS_EN is defined, compile in the starve_cnt mechanism of REQ-012 and REQ-022.
REQ-028 SHALL, when LSQ_ARB_FAIRNESS_EN is undefined, omit starve_cnt and STARVE_LIMIT logic and apply strict store priority, with the load granted only when stq_valid is low.

Structure
REQ-029 SHALL declare the FSM state enum (lsq_arb_state_t) and the dcache mask width constant in the shared lsu_types package.
REQ-030 SHALL be a single module with no sub-modules; the grant mux SHALL be an inline always_comb block.

Verification
REQ-031 SHALL verify: lone load to 0x1003, rmask 0xF, response 0xDEADBEEF two cycles later -> dc_addr 0x1000, ldq_resp_valid for one cycle with 0xDEADBEEF.
REQ-032 SHALL verify: store and load both valid in IDLE -> store granted first (dc_wmask = stq_wmask), load issued in the cycle after the store response.
REQ-033 SHALL verify (fairness on, STARVE_LIMIT = 4): stq_valid and ldq_valid held high -> four store transfers, then one load, then the count restarts.
REQ-034 SHALL verify: backend_flush in WAIT_LD, then response 0x12345678 -> ldq_resp_valid stays 0 and the FSM returns to IDLE.
REQ-035 SHALL verify: dc_ready low for 3 cycles with a store pending -> dc_valid held, stq_ready 0, and the transfer occurs in the first cycle dc_ready is high.
REQ-036 SHALL verify: rst asserted in WAIT_ST -> outputs go to 0 immediately, and a later dc_resp_valid produces no effect.
